// File: rtl/pl_shift_u.sv
// ---------------------------------------------------------------------------
// pl_shift_u
// Parametrised universal shift register with parallel load, shift and rotate
// in either direction, a serial port, and an autonomous burst-shift sequencer.
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   clr_n      : asynchronous active-low reset
//   load       : parallel load of dpl (highest priority in IDLE and SHIFT)
//   sft        : one manual shift this cycle (IDLE only)
//   dir        : 0 = shift right (toward bit 0), 1 = shift left
//   rot        : 1 = rotate, 0 = fill with sin
//   sin        : serial fill bit, always sampled live
//   start      : begin a burst of burst_len shifts (IDLE only)
//   burst_len  : burst shift count
//   dpl        : parallel load data
//   qpl        : register contents
//   sout       : bit that would leave the register on the next shift
//   busy       : burst in progress (SHIFT state)
//   done       : one-cycle pulse when a burst completes
//   state_dbg  : current sequencer state (0 IDLE, 1 SHIFT, 2 DONE)
//
// Handshake: start is a single-cycle command accepted only in IDLE; the
// burst ends with exactly one done cycle, after which the block is back in
// IDLE and accepts the next command on the following edge. A load during a
// burst aborts it without a done pulse.
// ---------------------------------------------------------------------------
module pl_shift_u #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             load,
    input  logic             sft,
    input  logic             dir,
    input  logic             rot,
    input  logic             sin,
    input  logic             start,
    input  logic [CW-1:0]    burst_len,
    input  logic [WIDTH-1:0] dpl,
    output logic [WIDTH-1:0] qpl,
    output logic             sout,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             bdir, bdir_nxt;
    logic             brot, brot_nxt;

    // One shift step. The exiting bit is the end the data moves toward; it
    // re-enters at the opposite end when rotating, otherwise sin does.
    function automatic logic [WIDTH-1:0] shift_once(
        input logic [WIDTH-1:0] q,
        input logic             d,
        input logic             r,
        input logic             s
    );
        logic ex;
        logic f;
        ex = d ? q[WIDTH-1] : q[0];
        f  = r ? ex : s;
        if (d) shift_once = {q[WIDTH-2:0], f};
        else   shift_once = {f, q[WIDTH-1:1]};
    endfunction

    // State register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            qpl  <= '0;
            cnt  <= '0;
            bdir <= 1'b0;
            brot <= 1'b0;
        end else begin
            qpl  <= q_nxt;
            cnt  <= cnt_nxt;
            bdir <= bdir_nxt;
            brot <= brot_nxt;
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_nxt = state;
        q_nxt     = qpl;
        cnt_nxt   = cnt;
        bdir_nxt  = bdir;
        brot_nxt  = brot;
        case (state)
            S_IDLE: begin
                if (load) begin
                    q_nxt = dpl;
                end else if (start) begin
                    if (burst_len != '0) begin
                        // Direction and mode are frozen for the whole burst.
                        bdir_nxt  = dir;
                        brot_nxt  = rot;
                        cnt_nxt   = burst_len;
                        state_nxt = S_SHIFT;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end else if (sft) begin
                    q_nxt = shift_once(qpl, dir, rot, sin);
                end
            end
            S_SHIFT: begin
                if (load) begin
                    q_nxt     = dpl;
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end else begin
                    q_nxt   = shift_once(qpl, bdir, brot, sin);
                    cnt_nxt = cnt - CW'(1);
                    if (cnt == CW'(1)) state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        logic d_eff;
        busy      = (state == S_SHIFT);
        done      = (state == S_DONE);
        d_eff     = (state == S_SHIFT) ? bdir : dir;
        sout      = d_eff ? qpl[WIDTH-1] : qpl[0];
        state_dbg = state;
    end

endmodule
